// File: rtl/midi_rx_byte.sv
// MIDI UART receiver (8N1, 31250 baud at 8 MHz) for one synchronized input.
// Serial frames become bytes on a valid/ready holding register. A low stop
// bit reports frame_err and parks the FSM in BREAK until the line goes high.
// The stop bit is sampled a full bit after the last data bit, and the FSM
// returns to IDLE there, half a bit before the frame really ends, so the
// next start edge is never missed.
// Build option: define MIDI_RX_RUNNING_STATUS_EN to track MIDI running
// status on status_byte; otherwise status_byte is tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge (start bit)
// START | counting to mid start bit to reject glitches
// DATA  | sampling 8 data bits LSB-first, one per CLKS_PER_BIT
// STOP  | sampling the stop bit; high delivers, low is a framing error
// BREAK | stop bit was low; wait for the line to return high

module midi_rx_byte #(
   parameter int CLKS_PER_BIT = 256,
   parameter int CNT_W        = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy,
   output logic [7:0] status_byte
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             deliver_q, deliver_d;
   logic             frame_err_q, frame_err_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             overrun_q, overrun_d;

   // Receiver state, bit timing and shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         deliver_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         deliver_q   <= deliver_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state logic; the counter is cleared at every sample point so it
   // never exceeds CLKS_PER_BIT-1
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      deliver_d   = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_in) begin
               cnt_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (!rx_in) begin
                  bit_idx_d = 3'd0;
                  state_d   = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {rx_in, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rx_in) begin
                  deliver_d = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BREAK: begin
            if (rx_in) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Holding register and overrun pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
      end
   end

   // Delivery in the cycle after the stop sample; an accept in that same
   // cycle frees the register so the new byte can replace the old one
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
      if (deliver_q) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

`ifdef MIDI_RX_RUNNING_STATUS_EN
   logic [7:0] status_q, status_d;

   // Running status register, updated on every delivered byte (even dropped)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= 8'h00;
      end else begin
         status_q <= status_d;
      end
   end

   // Channel messages set status, system common clears it, realtime and
   // data bytes leave it alone
   always_comb begin
      status_d = status_q;
      if (deliver_q && shift_q[7]) begin
         if (shift_q[7:4] != 4'hF) begin
            status_d = shift_q;
         end else if (!shift_q[3]) begin
            status_d = 8'h00;
         end
      end
   end

   assign status_byte = status_q;
`else
   assign status_byte = 8'h00;
`endif

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_midi_rx_byte.sv
// Directed bench for midi_rx_byte (CLKS_PER_BIT = 256).
// Inputs are driven 1 time unit after the rising edge, outputs are observed
// on the falling edge by a recorder that only counts events; each test task
// compares deltas of those counters against hand-computed values.

module tb_midi_rx_byte;

   localparam int CPB = 256;
`ifdef MIDI_RX_RUNNING_STATUS_EN
   localparam bit RS_EN = 1'b1;
`else
   localparam bit RS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_in = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;
   logic [7:0] status_byte;

   int n_checks = 0;
   int n_fail   = 0;

   int cyc = 0;
   int vcnt = 0, rises = 0, rise_cyc = 0, fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, data_chg = 0;
   logic [7:0] acc_q[$];
   logic       prev_valid = 1'b0, prev_ready = 1'b0;
   logic [7:0] prev_data = 8'h00;

   midi_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(9)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_in       (rx_in),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .busy        (busy),
      .status_byte (status_byte)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Event recorder on the falling edge
   always @(negedge clk) begin
      if (rx_valid) vcnt = vcnt + 1;
      if (rx_valid && !prev_valid) begin
         rises    = rises + 1;
         rise_cyc = cyc;
      end
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (overrun) ov_cnt = ov_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
      if (rst_n && prev_valid && !prev_ready && rx_valid && rx_data !== prev_data)
         data_chg = data_chg + 1;
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_data  = rx_data;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one 10-bit frame; t0 is the edge at which the DUT first sees the start bit
   task automatic send_frame(input logic [7:0] b, input logic stop_val, output int t0);
      logic [9:0] bits;
      bits = {stop_val, b, 1'b0};
      @(posedge clk);
      #1;
      t0 = cyc + 1;
      for (int i = 0; i < 10; i++) begin
         rx_in = bits[i];
         wait_cycles(CPB);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      rx_in = 1'b1;
      rx_ready = 1'b1;
      wait_cycles(3);
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %0h want 00", rx_data); end
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %0b want 0", rx_valid); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %0b want 0", frame_err); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
      n_checks++; if (status_byte !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %0h want 00", status_byte); end
      rst_n = 1'b1;
      wait_cycles(4);
   endtask

   task automatic test_single_byte;
      int t0, r0, v0, f0, b0, a0;
      rx_ready = 1'b1;
      r0 = rises; v0 = vcnt; f0 = fe_cnt; b0 = busy_cnt; a0 = acc_q.size();
      send_frame(8'h90, 1'b1, t0);
      wait_cycles(20);
      n_checks++; if (rises - r0 != 1) begin n_fail++; $display("FAIL single_rises: got %0d want 1", rises - r0); end
      n_checks++; if (rise_cyc != t0 + 2433) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", rise_cyc - t0, 2433); end
      n_checks++; if (vcnt - v0 != 1) begin n_fail++; $display("FAIL single_valid_width: got %0d want 1", vcnt - v0); end
      n_checks++; if (acc_q.size() - a0 != 1) begin n_fail++; $display("FAIL single_accepts: got %0d want 1", acc_q.size() - a0); end
      else begin
         n_checks++; if (acc_q[a0] !== 8'h90) begin n_fail++; $display("FAIL single_data: got %0h want 90", acc_q[a0]); end
      end
      n_checks++; if (fe_cnt - f0 != 0) begin n_fail++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt - f0); end
      n_checks++; if (busy_cnt - b0 != 2432) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want 2432", busy_cnt - b0); end
      n_checks++; if (status_byte !== (RS_EN ? 8'h90 : 8'h00)) begin n_fail++; $display("FAIL single_status: got %0h want %0h", status_byte, RS_EN ? 8'h90 : 8'h00); end
   endtask

   task automatic test_glitch;
      int t0, r0, f0, b0;
      r0 = rises; f0 = fe_cnt; b0 = busy_cnt;
      @(posedge clk);
      #1;
      t0 = cyc + 1;
      rx_in = 1'b0;
      wait_cycles(100);
      rx_in = 1'b1;
      wait_cycles(28);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_t127: got %0b want 1", busy); end
      wait_cycles(1);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_t128: got %0b want 0", busy); end
      wait_cycles(300);
      n_checks++; if (busy_cnt - b0 != 128) begin n_fail++; $display("FAIL glitch_busy_cycles: got %0d want 128", busy_cnt - b0); end
      n_checks++; if (rises - r0 != 0) begin n_fail++; $display("FAIL glitch_valid: got %0d want 0", rises - r0); end
      n_checks++; if (fe_cnt - f0 != 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - f0); end
   endtask

   task automatic test_frame_err;
      int t0, r0, f0;
      logic [7:0] st;
      r0 = rises; f0 = fe_cnt;
      st = status_byte;
      send_frame(8'h3C, 1'b0, t0);
      wait_cycles(5000);
      n_checks++; if (fe_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - f0); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break: got %0b want 1", busy); end
      rx_in = 1'b1;
      wait_cycles(2);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_idle_after_release: got %0b want 0", busy); end
      wait_cycles(50);
      n_checks++; if (rises - r0 != 0) begin n_fail++; $display("FAIL ferr_valid: got %0d want 0", rises - r0); end
      n_checks++; if (status_byte !== (RS_EN ? 8'h90 : 8'h00)) begin n_fail++; $display("FAIL ferr_status: got %0h want %0h", status_byte, RS_EN ? 8'h90 : 8'h00); end
   endtask

   task automatic test_overrun;
      int t0, o0, a0;
      rx_ready = 1'b0;
      o0 = ov_cnt; a0 = acc_q.size();
      send_frame(8'h90, 1'b1, t0);
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %0b want 1", rx_valid); end
      n_checks++; if (rx_data !== 8'h90) begin n_fail++; $display("FAIL ovr_first_data: got %0h want 90", rx_data); end
      send_frame(8'h40, 1'b1, t0);
      wait_cycles(5);
      n_checks++; if (ov_cnt - o0 != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", ov_cnt - o0); end
      n_checks++; if (rx_data !== 8'h90) begin n_fail++; $display("FAIL ovr_held_data: got %0h want 90", rx_data); end
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_held_valid: got %0b want 1", rx_valid); end
      n_checks++; if (status_byte !== (RS_EN ? 8'h90 : 8'h00)) begin n_fail++; $display("FAIL ovr_status: got %0h want %0h", status_byte, RS_EN ? 8'h90 : 8'h00); end
      rx_ready = 1'b1;
      wait_cycles(5);
      n_checks++; if (acc_q.size() - a0 != 1) begin n_fail++; $display("FAIL ovr_accepts: got %0d want 1", acc_q.size() - a0); end
      else begin
         n_checks++; if (acc_q[a0] !== 8'h90) begin n_fail++; $display("FAIL ovr_accepted_data: got %0h want 90", acc_q[a0]); end
      end
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop: got %0b want 0", rx_valid); end
   endtask

   task automatic test_back_to_back;
      int ta, tb, o0, a0;
      rx_ready = 1'b0;
      o0 = ov_cnt; a0 = acc_q.size();
      send_frame(8'h41, 1'b1, ta);
      fork
         send_frame(8'hC3, 1'b1, tb);
         begin
            wait_cycles(CPB * 9 + CPB / 2 + 1);
            rx_ready = 1'b1;
            wait_cycles(1);
            rx_ready = 1'b0;
         end
      join
      wait_cycles(3);
      n_checks++; if (acc_q.size() - a0 != 1) begin n_fail++; $display("FAIL b2b_first_accepts: got %0d want 1", acc_q.size() - a0); end
      else begin
         n_checks++; if (acc_q[a0] !== 8'h41) begin n_fail++; $display("FAIL b2b_first_data: got %0h want 41", acc_q[a0]); end
      end
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_kept: got %0b want 1", rx_valid); end
      n_checks++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_new_data: got %0h want c3", rx_data); end
      n_checks++; if (ov_cnt - o0 != 0) begin n_fail++; $display("FAIL b2b_overrun: got %0d want 0", ov_cnt - o0); end
      rx_ready = 1'b1;
      wait_cycles(4);
      n_checks++; if (acc_q.size() - a0 != 2) begin n_fail++; $display("FAIL b2b_total_accepts: got %0d want 2", acc_q.size() - a0); end
      else begin
         n_checks++; if (acc_q[a0+1] !== 8'hC3) begin n_fail++; $display("FAIL b2b_second_data: got %0h want c3", acc_q[a0+1]); end
      end
   endtask

   task automatic test_running_status;
      logic [7:0] bytes [4];
      logic [7:0] exp_st [4];
      int t0, a0;
      bytes  = '{8'h92, 8'hF8, 8'h40, 8'hF0};
      exp_st = '{8'h92, 8'h92, 8'h92, 8'h00};
      rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a0 = acc_q.size();
         send_frame(bytes[i], 1'b1, t0);
         wait_cycles(3);
         n_checks++; if (acc_q.size() - a0 != 1) begin n_fail++; $display("FAIL rs_accepts[%0d]: got %0d want 1", i, acc_q.size() - a0); end
         else begin
            n_checks++; if (acc_q[a0] !== bytes[i]) begin n_fail++; $display("FAIL rs_data[%0d]: got %0h want %0h", i, acc_q[a0], bytes[i]); end
         end
         n_checks++; if (status_byte !== (RS_EN ? exp_st[i] : 8'h00)) begin n_fail++; $display("FAIL rs_status[%0d]: got %0h want %0h", i, status_byte, RS_EN ? exp_st[i] : 8'h00); end
      end
   endtask

   task automatic test_reset_midframe;
      logic [9:0] bits;
      int t0, r0, a0;
      bits = {1'b1, 8'h55, 1'b0};
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         rx_in = bits[i];
         wait_cycles(CPB);
      end
      rx_in = bits[5];
      wait_cycles(100);
      rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %0b want 0", busy); end
      n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data: got %0h want 00", rx_data); end
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %0b want 0", rx_valid); end
      n_checks++; if (status_byte !== 8'h00) begin n_fail++; $display("FAIL mid_rst_status: got %0h want 00", status_byte); end
      rx_in = 1'b1;
      wait_cycles(5);
      rst_n = 1'b1;
      r0 = rises; a0 = acc_q.size();
      wait_cycles(3 * CPB);
      n_checks++; if (rises - r0 != 0) begin n_fail++; $display("FAIL mid_no_partial: got %0d want 0", rises - r0); end
      send_frame(8'hA5, 1'b1, t0);
      wait_cycles(3);
      n_checks++; if (rise_cyc != t0 + 2433) begin n_fail++; $display("FAIL mid_next_latency: got %0d want 2433", rise_cyc - t0); end
      n_checks++; if (acc_q.size() - a0 != 1) begin n_fail++; $display("FAIL mid_next_accepts: got %0d want 1", acc_q.size() - a0); end
      else begin
         n_checks++; if (acc_q[a0] !== 8'hA5) begin n_fail++; $display("FAIL mid_next_data: got %0h want a5", acc_q[a0]); end
      end
      n_checks++; if (status_byte !== (RS_EN ? 8'hA5 : 8'h00)) begin n_fail++; $display("FAIL mid_next_status: got %0h want %0h", status_byte, RS_EN ? 8'hA5 : 8'h00); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_running_status();
      test_reset_midframe();
      n_checks++; if (data_chg != 0) begin n_fail++; $display("FAIL data_stable_while_stalled: got %0d changes want 0", data_chg); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
